// File: rtl/cpu_pkg.sv
// Shared CPU definitions: execution-unit encodings, issue FSM states and
// default in-flight depth used by the issue stage and its scoreboard.
package cpu_pkg;

  localparam logic [1:0] UNIT_ALU  = 2'h0;
  localparam logic [1:0] UNIT_NONE = 2'h3;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_WAIT_BR = 1'b1;

  localparam int MAX_INFLIGHT_DEF = 4;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Pending-write mask for the issue stage; a same-cycle set beats a clear,
// and x0 never reads busy.
module issue_ctrl_scoreboard
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  output logic [31:0] busy
);

  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic [31:0] busy_nxt;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[set_idx] = 1'b1;
    if (clr_en) clr_vec[clr_idx] = 1'b1;
    busy_nxt    = (busy & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) busy <= '0;
    else                 busy <= busy_nxt;
  end

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue control: hazard check against the pending-write mask,
// in-flight limit, branch-wait FSM and a saturating stall counter.
module issue_ctrl
  import cpu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [1:0]      dec_unit,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  input  logic            dec_use_rs1,
  input  logic            dec_use_rs2,
  input  logic            dec_wr_rd,
  input  logic            dec_jump,
  output logic            iss_valid,
  output logic [1:0]      iss_unit,
  input  logic            iss_ready,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            br_done,
  input  logic            flush,
  output logic [31:0]     busy_o,
  output logic [XLEN-1:0] stall_cnt
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic [0:0]       state;
  logic [CNT_W-1:0] inflight;
  logic [31:0]      busy;
  logic             hazard;
  logic             can_issue;
  logic             issue;
  logic             wb_dec;

  // Hazards use the registered mask only; a writeback frees its register
  // for issue one cycle later.
  assign hazard = (dec_use_rs1 && busy[dec_rs1]) ||
                  (dec_use_rs2 && busy[dec_rs2]) ||
                  (dec_wr_rd   && busy[dec_rd]);

  assign can_issue = rst_n && (state == ST_RUN) && !hazard &&
                     (inflight < CNT_W'(MAX_INFLIGHT)) && iss_ready && !flush;

  assign issue     = dec_valid && can_issue;
  assign dec_ready = can_issue;
  assign iss_valid = issue;
  assign iss_unit  = issue ? dec_unit : UNIT_NONE;
  assign wb_dec    = wb_valid && (inflight != '0);
  assign busy_o    = busy;

  issue_ctrl_scoreboard u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .set_en  (issue && dec_wr_rd && (dec_rd != 5'd0)),
    .set_idx (dec_rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .busy    (busy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      inflight <= '0;
      state    <= ST_RUN;
    end else begin
      if (issue && !wb_dec)      inflight <= inflight + 1'b1;
      else if (!issue && wb_dec) inflight <= inflight - 1'b1;

      if (state == ST_RUN && issue && dec_jump) state <= ST_WAIT_BR;
      else if (state == ST_WAIT_BR && br_done)  state <= ST_RUN;
    end
  end

  // Survives flush: it is a performance counter, not pipeline state.
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (dec_valid && !can_issue && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
